// File: rtl/lif_param_loader_pkg.sv
// Shared types and constants for the LIF parameter loader: FSM states, status codes,
// B1 field layout and the reset defaults used when LIF_LOADER_DEFAULTS_EN is defined.
package lif_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CFG    = 3'd1,
    TMIN   = 3'd2,
    TMAX   = 3'd3,
    CSUM   = 3'd4,
    COMMIT = 3'd5
  } loader_state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam int B1_WA_MSB   = 7;
  localparam int B1_WA_LSB   = 5;
  localparam int B1_WB_MSB   = 4;
  localparam int B1_WB_LSB   = 2;
  localparam int B1_LEAK_MSB = 1;
  localparam int B1_LEAK_LSB = 0;

  localparam logic [2:0] DEF_WEIGHT_A      = 3'd3;
  localparam logic [2:0] DEF_WEIGHT_B      = 3'd3;
  localparam logic [1:0] DEF_LEAK_CONFIG   = 2'd1;
  localparam logic [7:0] DEF_THRESHOLD_MIN = 8'd20;
  localparam logic [7:0] DEF_THRESHOLD_MAX = 8'd120;

  function automatic logic [7:0] frame_csum(input logic [7:0] cfg, input logic [7:0] tmin,
                                            input logic [7:0] tmax);
    return cfg ^ tmin ^ tmax;
  endfunction

endpackage

// File: rtl/lif_gap_timer.sv
// Saturating idle-gap counter; expired flags the cycle that completes TIMEOUT_CYCLES
// consecutive enabled cycles, so the caller can act on that same edge.
module lif_gap_timer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int W              = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST  = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_r;

  // gap counter: clears on request, counts while enabled, saturates at the limit
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LIMIT)) begin
      count_r <= count_r + W'(1);
    end
  end

  assign expired = enable && (count_r >= LAST);

endmodule

// File: rtl/lif_param_loader.sv
// Framed byte-stream loader for LIF neuron parameters with checksum/range validation and
// atomic commit. Define LIF_LOADER_DEFAULTS_EN to reset into a usable parameter set.
module lif_param_loader
  import lif_cfg_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] weight_a,
  output logic [2:0] weight_b,
  output logic [1:0] leak_config,
  output logic [7:0] threshold_min,
  output logic [7:0] threshold_max,
  output logic       params_ready,
  output logic       frame_done,
  output logic [1:0] err_code
);

  loader_state_t state_r, next_state_s;
  logic [7:0] cfg_sh_r, tmin_sh_r, tmax_sh_r;
  logic       csum_err_r, range_err_r;
  logic       accept_s, in_frame_s, gap_expired_s;

  assign accept_s   = in_valid && in_ready;
  assign in_frame_s = (state_r == CFG) || (state_r == TMIN) || (state_r == TMAX) ||
                      (state_r == CSUM);

  lif_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept_s || !in_frame_s),
    .enable  (in_frame_s && !accept_s),
    .expired (gap_expired_s)
  );

  // next-state decode; a sync value inside the frame is plain data
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && (in_data == SYNC_BYTE)) next_state_s = CFG;
        else                                    next_state_s = IDLE;
      end
      CFG: begin
        if (accept_s)           next_state_s = TMIN;
        else if (gap_expired_s) next_state_s = IDLE;
        else                    next_state_s = CFG;
      end
      TMIN: begin
        if (accept_s)           next_state_s = TMAX;
        else if (gap_expired_s) next_state_s = IDLE;
        else                    next_state_s = TMIN;
      end
      TMAX: begin
        if (accept_s)           next_state_s = CSUM;
        else if (gap_expired_s) next_state_s = IDLE;
        else                    next_state_s = TMAX;
      end
      CSUM: begin
        if (accept_s)           next_state_s = COMMIT;
        else if (gap_expired_s) next_state_s = IDLE;
        else                    next_state_s = CSUM;
      end
      COMMIT:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // state register; in_ready is registered off the next state so it drops for COMMIT only
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      in_ready <= 1'b1;
    end else begin
      state_r  <= next_state_s;
      in_ready <= (next_state_s != COMMIT);
    end
  end

  // shadow capture and frame checks, evaluated when the checksum byte arrives
  always_ff @(posedge clk) begin
    if (accept_s) begin
      case (state_r)
        CFG:  cfg_sh_r  <= in_data;
        TMIN: tmin_sh_r <= in_data;
        TMAX: tmax_sh_r <= in_data;
        CSUM: begin
          csum_err_r  <= (in_data != frame_csum(cfg_sh_r, tmin_sh_r, tmax_sh_r));
          range_err_r <= (tmin_sh_r > tmax_sh_r);
        end
        default: ;
      endcase
    end
  end

  // committed parameter set and status; the old set is held until a clean commit
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef LIF_LOADER_DEFAULTS_EN
      weight_a      <= DEF_WEIGHT_A;
      weight_b      <= DEF_WEIGHT_B;
      leak_config   <= DEF_LEAK_CONFIG;
      threshold_min <= DEF_THRESHOLD_MIN;
      threshold_max <= DEF_THRESHOLD_MAX;
      params_ready  <= 1'b1;
`else
      weight_a      <= 3'd0;
      weight_b      <= 3'd0;
      leak_config   <= 2'd0;
      threshold_min <= 8'd0;
      threshold_max <= 8'd0;
      params_ready  <= 1'b0;
`endif
      frame_done    <= 1'b0;
      err_code      <= ERR_OK;
    end else begin
      frame_done <= 1'b0;
      if (state_r == COMMIT) begin
        if (csum_err_r) begin
          err_code <= ERR_CSUM;
        end else if (range_err_r) begin
          err_code <= ERR_RANGE;
        end else begin
          weight_a      <= cfg_sh_r[B1_WA_MSB:B1_WA_LSB];
          weight_b      <= cfg_sh_r[B1_WB_MSB:B1_WB_LSB];
          leak_config   <= cfg_sh_r[B1_LEAK_MSB:B1_LEAK_LSB];
          threshold_min <= tmin_sh_r;
          threshold_max <= tmax_sh_r;
          params_ready  <= 1'b1;
          frame_done    <= 1'b1;
          err_code      <= ERR_OK;
        end
      end else if (gap_expired_s) begin
        err_code <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_lif_param_loader.sv
// Scoreboard bench for lif_param_loader: frames push hand-computed commit results, a
// negedge monitor pops them whenever the DUT enters its commit cycle.
module tb_lif_param_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] weight_a, weight_b;
  logic [1:0] leak_config;
  logic [7:0] threshold_min, threshold_max;
  logic       params_ready, frame_done;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  lif_param_loader dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .weight_a      (weight_a),
    .weight_b      (weight_b),
    .leak_config   (leak_config),
    .threshold_min (threshold_min),
    .threshold_max (threshold_max),
    .params_ready  (params_ready),
    .frame_done    (frame_done),
    .err_code      (err_code)
  );

  // {err, wa, wb, leak, tmin, tmax, params_ready, frame_done}
  typedef struct packed {
    logic [1:0] err;
    logic [2:0] wa;
    logic [2:0] wb;
    logic [1:0] leak;
    logic [7:0] tmin;
    logic [7:0] tmax;
    logic       pr;
    logic       fd;
  } obs_t;

`ifdef LIF_LOADER_DEFAULTS_EN
  localparam obs_t RST_OBS = {2'b00, 3'd3, 3'd3, 2'd1, 8'd20, 8'd120, 1'b1, 1'b0};
`else
  localparam obs_t RST_OBS = {2'b00, 3'd0, 3'd0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0};
`endif

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   pending  = 1'b0;
  bit   fd_chk   = 1'b0;

  function automatic obs_t cur_obs();
    return {err_code, weight_a, weight_b, leak_config, threshold_min, threshold_max,
            params_ready, frame_done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: in_ready low marks COMMIT; the next negedge shows the commit result
  always @(negedge clk) begin
    if (reset) begin
      pending = 1'b0;
      fd_chk  = 1'b0;
    end else begin
      if (fd_chk) begin
        chk("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);
        chk("in_ready_low_one_cycle", {31'd0, in_ready}, 32'd1);
        fd_chk = 1'b0;
      end
      if (pending) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit actual=%0h required=none", cur_obs());
        end else begin
          chk("commit_result", {4'd0, cur_obs()}, {4'd0, exp_q.pop_front()});
        end
        pending = 1'b0;
        fd_chk  = 1'b1;
      end
      if (!in_ready) pending = 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(posedge clk);
      if (in_ready) break;
      n++;
      if (n > 20) begin
        chk("byte_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input obs_t e);
    exp_q.push_back(e);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    send_byte(b4);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_state", {4'd0, cur_obs()}, {4'd0, RST_OBS});
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // good frame, bad checksum, range error, then tmin == tmax, streamed back to back
    send_frame(8'hA5, 8'hAE, 8'h10, 8'h40, 8'hFE, {2'b00, 3'd5, 3'd3, 2'd2, 8'h10, 8'h40, 1'b1, 1'b1});
    send_frame(8'hA5, 8'hAE, 8'h10, 8'h40, 8'h00, {2'b01, 3'd5, 3'd3, 2'd2, 8'h10, 8'h40, 1'b1, 1'b0});
    send_frame(8'hA5, 8'h24, 8'h50, 8'h30, 8'h44, {2'b10, 3'd5, 3'd3, 2'd2, 8'h10, 8'h40, 1'b1, 1'b0});
    send_frame(8'hA5, 8'h24, 8'h30, 8'h30, 8'h24, {2'b00, 3'd1, 3'd1, 2'd0, 8'h30, 8'h30, 1'b1, 1'b1});
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // timeout boundary: still in frame after 63 idle cycles, aborted on the 64th
    send_byte(8'hA5);
    send_byte(8'hAE);
    in_valid = 1'b0;
    repeat (63) @(posedge clk);
    #1 chk("timeout_not_before_64", {30'd0, err_code}, 32'd0);
    @(posedge clk);
    #1 chk("timeout_err", {30'd0, err_code}, 32'd3);
    chk("timeout_outputs_held", {4'd0, cur_obs()},
        {4'd0, 2'b11, 3'd1, 3'd1, 2'd0, 8'h30, 8'h30, 1'b1, 1'b0});
    send_byte(8'h00);
    send_byte(8'h13);
    send_frame(8'hA5, 8'hAE, 8'h10, 8'h40, 8'hFE, {2'b00, 3'd5, 3'd3, 2'd2, 8'h10, 8'h40, 1'b1, 1'b1});
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset mid-frame; trailing bytes are junk in IDLE
    send_byte(8'hA5);
    send_byte(8'hAE);
    send_byte(8'h10);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midframe_reset_state", {4'd0, cur_obs()}, {4'd0, RST_OBS});
    send_byte(8'h40);
    send_byte(8'hFE);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("trailing_bytes_ignored", {4'd0, cur_obs()}, {4'd0, RST_OBS});

    // a fresh frame overrides the reset set (defaults or zeros)
    send_frame(8'hA5, 8'h24, 8'h30, 8'h30, 8'h24, {2'b00, 3'd1, 3'd1, 2'd0, 8'h30, 8'h30, 1'b1, 1'b1});
    in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1 chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
